// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage.
// Load funct3 encodings and ctrlWB bit positions.
package wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/wb_load_align.sv
// Load byte/half/word extraction with sign or zero extension.
// Also flags loads whose address is misaligned for their size.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_value,
  output logic            o_misaligned
);

  logic       w_is_byte;
  logic       w_is_half;
  logic       w_is_word;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  assign w_is_byte = (i_funct3 == LB) || (i_funct3 == LBU);
  assign w_is_half = (i_funct3 == LH) || (i_funct3 == LHU);
  // Anything that is not a byte or half load behaves as LW.
  assign w_is_word = !w_is_byte && !w_is_half;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    w_byte = i_data[7:0];
    case (i_offset)
      2'd0: w_byte = i_data[7:0];
      2'd1: w_byte = i_data[15:8];
      2'd2: w_byte = i_data[23:16];
      2'd3: w_byte = i_data[31:24];
      default: w_byte = i_data[7:0];
    endcase
    w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
  end

  // Extend the selected lane; bit 2 of funct3 marks unsigned loads.
  always_comb begin
    o_value = i_data;
    unique case (1'b1)
      w_is_byte: o_value = i_funct3[2]
        ? {{(XLEN-8){1'b0}}, w_byte}
        : {{(XLEN-8){w_byte[7]}}, w_byte};
      w_is_half: o_value = i_funct3[2]
        ? {{(XLEN-16){1'b0}}, w_half}
        : {{(XLEN-16){w_half[15]}}, w_half};
      default: o_value = i_data;
    endcase
  end

  assign o_misaligned = (w_is_half && i_offset[0])
                     || (w_is_word && (i_offset != 2'd0));

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment and writeback select.
// Optional retirement counter enabled by WB_RETIRE_CNT_EN.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [1:0]            i_ctrlWB,
  input  logic [2:0]            i_funct3,
  input  logic [XLEN-1:0]       i_aluResult,
  input  logic [XLEN-1:0]       i_readData,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  o_valid,
  output logic                  o_regWrite,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [XLEN-1:0]       o_wbData,
  output logic                  o_misaligned
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           o_retireCount
`endif
);

  logic                  r_valid;
  logic [1:0]            r_ctrl;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_alu;
  logic [XLEN-1:0]       r_rdata;
  logic [REG_ADDR_W-1:0] r_rd;

  logic [XLEN-1:0] w_load;
  logic            w_load_mis;
  logic            w_regwrite;
  logic            w_memtoreg;

  // Stage register: flush beats stall, stall beats capture.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_funct3 <= '0;
      r_alu    <= '0;
      r_rdata  <= '0;
      r_rd     <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!i_stall) begin
      r_valid  <= i_valid;
      r_ctrl   <= i_ctrlWB;
      r_funct3 <= i_funct3;
      r_alu    <= i_aluResult;
      r_rdata  <= i_readData;
      r_rd     <= i_rd;
    end
  end

  wb_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_data      (r_rdata),
    .i_offset    (r_alu[1:0]),
    .i_funct3    (r_funct3),
    .o_value     (w_load),
    .o_misaligned(w_load_mis)
  );

  assign w_memtoreg = r_ctrl[WB_MEMTOREG];
  assign w_regwrite = r_valid && r_ctrl[WB_REGWRITE]
                   && (r_rd != '0);

  assign o_valid      = r_valid;
  assign o_regWrite   = w_regwrite;
  assign o_rd         = w_regwrite ? r_rd : '0;
  assign o_misaligned = r_valid && w_memtoreg && w_load_mis;

  // Bubbles drive zero so forwarding never sees stale data.
  always_comb begin
    o_wbData = '0;
    if (r_valid) begin
      o_wbData = w_memtoreg ? w_load : r_alu;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  // Count each held instruction once, on the edge it leaves WB.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_retire_cnt <= '0;
    end else if (r_valid && !i_stall) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign o_retireCount = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
// Define WB_RETIRE_CNT_EN to also exercise the retirement counter.
module tb_mem_wb_stage;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic [1:0]  i_ctrlWB;
  logic [2:0]  i_funct3;
  logic [31:0] i_aluResult;
  logic [31:0] i_readData;
  logic [4:0]  i_rd;
  logic        o_valid;
  logic        o_regWrite;
  logic [4:0]  o_rd;
  logic [31:0] o_wbData;
  logic        o_misaligned;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] o_retireCount;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .i_ctrlWB    (i_ctrlWB),
    .i_funct3    (i_funct3),
    .i_aluResult (i_aluResult),
    .i_readData  (i_readData),
    .i_rd        (i_rd),
    .o_valid     (o_valid),
    .o_regWrite  (o_regWrite),
    .o_rd        (o_rd),
    .o_wbData    (o_wbData),
    .o_misaligned(o_misaligned)
`ifdef WB_RETIRE_CNT_EN
    ,
    .o_retireCount(o_retireCount)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive(input logic v, input logic [1:0] c,
                       input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    i_valid     = v;
    i_ctrlWB    = c;
    i_funct3    = f;
    i_aluResult = a;
    i_readData  = d;
    i_rd        = rd;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    drive(1'b1, 2'b10, 3'b010, 32'h1234, 32'h0, 5'd5);
    step();
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", o_valid);
    end
    checks++;
    if (o_regWrite !== 1'b0 || o_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_wr got %0b/%0d want 0/0", o_regWrite, o_rd);
    end
    checks++;
    if (o_wbData !== 32'h0 || o_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got %h/%0b want 0/0",
               o_wbData, o_misaligned);
    end
    i_reset_n = 1'b1;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_regWrite !== 1'b1 || o_rd !== 5'd5
        || o_wbData !== 32'h1234) begin
      errors++;
      $display("FAIL alu_capture got v%0b w%0b rd%0d %h want 1 1 5 1234",
               o_valid, o_regWrite, o_rd, o_wbData);
    end
  endtask

  task automatic test_load_byte();
    drive(1'b1, 2'b11, 3'b000, 32'h103, 32'h80FF_0000, 5'd6);
    step();
    checks++;
    if (o_wbData !== 32'hFFFF_FF80 || o_rd !== 5'd6) begin
      errors++;
      $display("FAIL lb got %h rd%0d want ffffff80 rd6", o_wbData, o_rd);
    end
    drive(1'b1, 2'b11, 3'b100, 32'h103, 32'h80FF_0000, 5'd6);
    step();
    checks++;
    if (o_wbData !== 32'h0000_0080 || o_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL lbu got %h mis%0b want 00000080 0",
               o_wbData, o_misaligned);
    end
    drive(1'b1, 2'b11, 3'b000, 32'h201, 32'h0000_7F00, 5'd7);
    step();
    checks++;
    if (o_wbData !== 32'h0000_007F) begin
      errors++;
      $display("FAIL lb_pos got %h want 0000007f", o_wbData);
    end
  endtask

  task automatic test_load_half();
    drive(1'b1, 2'b11, 3'b001, 32'h102, 32'h8001_0000, 5'd8);
    step();
    checks++;
    if (o_wbData !== 32'hFFFF_8001 || o_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL lh got %h mis%0b want ffff8001 0",
               o_wbData, o_misaligned);
    end
    drive(1'b1, 2'b11, 3'b101, 32'h101, 32'h8001_0000, 5'd8);
    step();
    checks++;
    if (o_wbData !== 32'h0 || o_misaligned !== 1'b1
        || o_regWrite !== 1'b1) begin
      errors++;
      $display("FAIL lhu_mis got %h mis%0b w%0b want 00000000 1 1",
               o_wbData, o_misaligned, o_regWrite);
    end
  endtask

  task automatic test_load_word();
    drive(1'b1, 2'b11, 3'b010, 32'h100, 32'hCAFE_BABE, 5'd9);
    step();
    checks++;
    if (o_wbData !== 32'hCAFE_BABE || o_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL lw got %h mis%0b want cafebabe 0",
               o_wbData, o_misaligned);
    end
    drive(1'b1, 2'b11, 3'b010, 32'h102, 32'hCAFE_BABE, 5'd9);
    step();
    checks++;
    if (o_wbData !== 32'hCAFE_BABE || o_misaligned !== 1'b1) begin
      errors++;
      $display("FAIL lw_mis got %h mis%0b want cafebabe 1",
               o_wbData, o_misaligned);
    end
    drive(1'b1, 2'b11, 3'b111, 32'h100, 32'h1357_9BDF, 5'd9);
    step();
    checks++;
    if (o_wbData !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL f3_other got %h want 13579bdf", o_wbData);
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 2'b10, 3'b010, 32'hDEAD, 32'h0, 5'd0);
    step();
    checks++;
    if (o_regWrite !== 1'b0 || o_rd !== 5'd0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL x0 got w%0b rd%0d v%0b want 0 0 1",
               o_regWrite, o_rd, o_valid);
    end
    drive(1'b1, 2'b01, 3'b010, 32'h44, 32'h0, 5'd4);
    step();
    checks++;
    if (o_regWrite !== 1'b0 || o_rd !== 5'd0) begin
      errors++;
      $display("FAIL nowrite got w%0b rd%0d want 0 0", o_regWrite, o_rd);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 2'b11, 3'b101, 32'h101, 32'hFFFF_FFFF, 5'd7);
    step();
    checks++;
    if (o_valid !== 1'b0 || o_regWrite !== 1'b0 || o_rd !== 5'd0
        || o_wbData !== 32'h0 || o_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL bubble got v%0b w%0b rd%0d %h m%0b want all 0",
               o_valid, o_regWrite, o_rd, o_wbData, o_misaligned);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 2'b10, 3'b010, 32'hAAAA, 32'h0, 5'd9);
    step();
    i_stall = 1'b1;
    drive(1'b1, 2'b11, 3'b000, 32'h5555, 32'hFFFF_FFFF, 5'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (o_rd !== 5'd9 || o_wbData !== 32'hAAAA
          || o_regWrite !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d got rd%0d %h w%0b want 9 aaaa 1",
                 k, o_rd, o_wbData, o_regWrite);
      end
    end
    i_stall = 1'b0;
    drive(1'b1, 2'b10, 3'b010, 32'h5555, 32'h0, 5'd3);
    step();
    checks++;
    if (o_rd !== 5'd3 || o_wbData !== 32'h5555) begin
      errors++;
      $display("FAIL unstall got rd%0d %h want 3 5555", o_rd, o_wbData);
    end
  endtask

  task automatic test_flush_stall();
    i_flush = 1'b1;
    i_stall = 1'b1;
    drive(1'b1, 2'b10, 3'b010, 32'h7777, 32'h0, 5'd11);
    step();
    checks++;
    if (o_valid !== 1'b0 || o_regWrite !== 1'b0 || o_rd !== 5'd0
        || o_wbData !== 32'h0) begin
      errors++;
      $display("FAIL flush got v%0b w%0b rd%0d %h want 0 0 0 0",
               o_valid, o_regWrite, o_rd, o_wbData);
    end
    i_flush = 1'b0;
    i_stall = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b10, 3'b010, 32'h9999, 32'h0, 5'd12);
    step();
    checks++;
    if (o_valid !== 1'b1 || o_rd !== 5'd12) begin
      errors++;
      $display("FAIL pre_areset got v%0b rd%0d want 1 12", o_valid, o_rd);
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_regWrite !== 1'b0 || o_rd !== 5'd0
        || o_wbData !== 32'h0 || o_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL areset got v%0b w%0b rd%0d %h m%0b want all 0",
               o_valid, o_regWrite, o_rd, o_wbData, o_misaligned);
    end
    step();
    i_reset_n = 1'b1;
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire();
    i_reset_n = 1'b0;
    drive(1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 5'd0);
    step();
    checks++;
    if (o_retireCount !== 64'd0) begin
      errors++;
      $display("FAIL retire_rst got %0d want 0", o_retireCount);
    end
    i_reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b10, 3'b010, 32'(k), 32'h0, 5'd1);
      step();
    end
    i_stall = 1'b1;
    step();
    checks++;
    if (o_retireCount !== 64'd3) begin
      errors++;
      $display("FAIL retire_stall got %0d want 3", o_retireCount);
    end
    i_stall = 1'b0;
    drive(1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 5'd0);
    step();
    step();
    checks++;
    if (o_retireCount !== 64'd4) begin
      errors++;
      $display("FAIL retire4 got %0d want 4", o_retireCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_load_word();
    test_x0();
    test_bubble();
    test_stall();
    test_flush_stall();
    test_async_reset();
`ifdef WB_RETIRE_CNT_EN
    test_retire();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Pipeline stage directly downstream of the data-memory stage. It registers the MEM-stage results (ALU result, load data, destination register, writeback controls), then performs load byte/half extraction with sign/zero extension. It selects the final writeback value and drives the register-file write port and the forwarding path. Adds stall/flush control and a valid bit, so bubbles never write the register file.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register-file address width

Ports:
i_clk  input  1  core clock; all state updates on posedge
i_reset_n  input  1  asynchronous active-low reset
i_stall  input  1  hold all stage registers this cycle
i_flush  input  1  insert bubble (valid=0) this cycle
i_valid  input  1  MEM-stage instruction is valid
i_ctrlWB  input  2  {RegWrite, MemToReg}
i_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
i_aluResult  input  XLEN  ALU result / memory byte address
i_readData  input  XLEN  word read from data memory (valid since preceding negedge)
i_rd  input  REG_ADDR_W  destination register
o_valid  output  1  registered instruction is valid
o_regWrite  output  1  register-file write enable
o_rd  output  REG_ADDR_W  register-file write address
o_wbData  output  XLEN  register-file write data / forwarding value
o_misaligned  output  1  registered load is misaligned for its size

Behaviour:
- Reset (async, i_reset_n=0): all stage registers cleared. o_valid=0, o_regWrite=0, o_rd=0, o_wbData=0, o_misaligned=0. Reset mid-stall or mid-flush wins immediately.
- Posedge priority: i_flush > i_stall > capture.
  - Flush: valid reg <= 0, ctrl reg <= 0; data regs are don't-care and may hold.
  - Stall: every register holds its value.
  - Otherwise: capture i_valid, i_ctrlWB, i_funct3, i_aluResult, i_readData, i_rd.
- Latency: exactly one cycle from MEM inputs to outputs. All outputs are combinational from stage registers only; no input-to-output path.
- o_regWrite = valid_q & RegWrite_q & (rd_q != 0). Writes to x0 are always suppressed.
- o_rd = rd_q when o_regWrite, else 0.
- Writeback select: MemToReg_q=0 -> o_wbData = aluResult_q. MemToReg_q=1 -> o_wbData = extracted load value.
- Load extraction, offset = aluResult_q[1:0]:
  - LB/LBU: byte = readData_q[8*offset +: 8]; LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU: half = readData_q[16*offset[1] +: 16]; LH sign-extends bit 15, LHU zero-extends.
  - LW: whole word.
  - Unlisted funct3 codes: treated as LW.
- o_misaligned = valid_q & MemToReg_q & ((half load & offset[0]) | (LW & offset != 0)). Data is still produced using the rule above. The flag does not block the write.
- When valid_q=0: o_wbData is driven 0 and o_misaligned=0.

Optional Feature:
WB_RETIRE_CNT_EN: adds output o_retireCount [63:0]. The counter resets to 0 and increments by 1 on each posedge where valid_q=1 and no stall occurs (one retirement per held instruction). It wraps 2^64-1 -> 0. Without the macro, the port and counter do not exist.

Decomposition:
- Shared package wb_pkg: load funct3 localparams (LB, LH, LW, LBU, LHU) and a ctrlWB bit-index constant pair (WB_REGWRITE=1, WB_MEMTOREG=0).
- One natural sub-module: wb_load_align, a purely combinational extraction/extension from (readData, offset, funct3) to value plus misaligned flag.

Test Plan:
- Reset held with i_valid=1, RegWrite=1 -> all outputs 0. Release, capture ALU op rd=5, aluResult=0x1234 -> next cycle o_regWrite=1, o_rd=5, o_wbData=0x1234.
- LB, addr=0x103, readData=0x80FF_0000 -> o_wbData=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LH, addr=0x102, readData=0x8001_0000 -> 0xFFFF_8001. LHU, addr=0x101 -> o_misaligned=1, o_wbData=0x0000_0000 (lower half).
- RegWrite=1, rd=0, aluResult=0xDEAD -> o_regWrite=0, o_rd=0.
- Stall for 3 cycles with new inputs applied -> outputs unchanged. Assert i_flush and i_stall together -> next cycle o_valid=0, o_regWrite=0.
- Async reset asserted mid-cycle between edges -> outputs 0 without a clock edge. With WB_RETIRE_CNT_EN, 4 valid unstalled retirements -> o_retireCount=4.
